// File: rtl/btn_debounce_if.sv
// btn_debounce_if: groups the button input and the debounced outputs.
//   btn_in        raw asynchronous button, 1 = pressed
//   btn_level     debounced level
//   press_pulse   one-cycle pulse on an accepted press
//   release_pulse one-cycle pulse on an accepted release
//   long_press    one-cycle pulse once a press has been held long enough
//   press_count   8-bit wrapping count of accepted presses
// master: the side that owns the pin and reads the events.
// slave:  the debouncer itself.
interface btn_debounce_if;
  logic       btn_in;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_press;
  logic [7:0] press_count;

  modport master (
    output btn_in,
    input  btn_level, press_pulse, release_pulse, long_press, press_count
  );

  modport slave (
    input  btn_in,
    output btn_level, press_pulse, release_pulse, long_press, press_count
  );
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: debounces one raw active-high button into a clean level,
// single-cycle press/release/long-press events and a wrapping press count.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    btn_debounce_if.slave (btn_in in; level, pulses, count out)
// Every output is a flop output; btn_in only reaches logic through s1/s2.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 100_000_000
) (
  input  logic           clk,
  input  logic           rst_n,
  btn_debounce_if.slave  bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] H_MAX  = HW'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  state_t        state;
  logic          s1;
  logic          s2;
  logic [DW-1:0] dcnt;
  logic [HW-1:0] hcnt;
  logic          level_r;
  logic          press_r;
  logic          release_r;
  logic          long_r;
  logic [7:0]    count_r;

  // Hold counter saturates so long_press can only fire once per press.
  function automatic logic [HW-1:0] hold_next(input logic [HW-1:0] h);
    return (h == H_MAX) ? h : h + HW'(1);
  endfunction

  // Stage: two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= bus.btn_in;
      s2 <= s1;
    end
  end

  // Stage: debounce FSM with registered level, events and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dcnt      <= '0;
      hcnt      <= '0;
      level_r   <= 1'b0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
      long_r    <= 1'b0;
      count_r   <= 8'd0;
    end else begin
      press_r   <= 1'b0;
      release_r <= 1'b0;
      long_r    <= 1'b0;
      case (state)
        IDLE: begin
          if (s2) begin
            state <= PRESS_WAIT;
            dcnt  <= DW'(1);
          end else begin
            dcnt  <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!s2) begin
            state <= IDLE;
            dcnt  <= '0;
          end else if (dcnt == D_LAST) begin
            state   <= PRESSED;
            level_r <= 1'b1;
            press_r <= 1'b1;
            count_r <= count_r + 8'd1;
            hcnt    <= '0;
            dcnt    <= '0;
          end else begin
            dcnt  <= dcnt + DW'(1);
          end
        end
        PRESSED: begin
          if (!s2) begin
            state <= RELEASE_WAIT;
            dcnt  <= DW'(1);
          end
          hcnt   <= hold_next(hcnt);
          long_r <= (hcnt == H_LAST);
        end
        RELEASE_WAIT: begin
          if (s2) begin
            state  <= PRESSED;
            dcnt   <= '0;
            hcnt   <= hold_next(hcnt);
            long_r <= (hcnt == H_LAST);
          end else if (dcnt == D_LAST) begin
            // Release wins over a coincident long press so events stay exclusive.
            state     <= IDLE;
            level_r   <= 1'b0;
            release_r <= 1'b1;
            hcnt      <= '0;
            dcnt      <= '0;
          end else begin
            dcnt   <= dcnt + DW'(1);
            hcnt   <= hold_next(hcnt);
            long_r <= (hcnt == H_LAST);
          end
        end
        default: begin
          state <= IDLE;
          dcnt  <= '0;
        end
      endcase
    end
  end

  assign bus.btn_level     = level_r;
  assign bus.press_pulse   = press_r;
  assign bus.release_pulse = release_r;
  assign bus.long_press    = long_r;
  assign bus.press_count   = count_r;

endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: directed bench for btn_debounce with DEBOUNCE_CYCLES=4,
// HOLD_CYCLES=10. Expected events (kind, cycle, count, level) are queued
// when stimulus is applied and matched when the DUT pulses.
module tb_btn_debounce;

  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int LAT  = DEB + 2;

  localparam int K_PRESS = 4;
  localparam int K_REL   = 2;
  localparam int K_LONG  = 1;

  typedef struct {
    int kind;
    int cyc;
    int count;
    int level;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   exp_count = 0;
  ev_t  q[$];

  btn_debounce_if bus ();

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES    (HOLD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic check_clear(input string tag);
    check({tag, "_level"},   32'(bus.btn_level),     0);
    check({tag, "_press"},   32'(bus.press_pulse),   0);
    check({tag, "_release"}, 32'(bus.release_pulse), 0);
    check({tag, "_long"},    32'(bus.long_press),    0);
    check({tag, "_count"},   32'(bus.press_count),   0);
  endtask

  task automatic push_ev(input int kind, input int at, input int cnt, input int lvl);
    ev_t e;
    e.kind  = kind;
    e.cyc   = at;
    e.count = cnt;
    e.level = lvl;
    q.push_back(e);
  endtask

  // Called at a negedge right where btn_in is set to its new stable value.
  task automatic expect_press(input bit with_long);
    exp_count = (exp_count + 1) % 256;
    push_ev(K_PRESS, cyc + LAT, exp_count, 1);
    if (with_long) push_ev(K_LONG, cyc + LAT + HOLD, exp_count, 1);
  endtask

  task automatic expect_release();
    push_ev(K_REL, cyc + LAT, exp_count, 0);
  endtask

  task automatic hold(input logic v, input int n);
    bus.btn_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", q.size(), 0);
  endtask

  // Event monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin : mon
    logic [2:0] k;
    ev_t        e;
    if (rst_n === 1'b1) begin
      k = {bus.press_pulse, bus.release_pulse, bus.long_press};
      if (k != 3'b000) begin
        check("one_event", $countones(k), 1);
        if (q.size() == 0) begin
          check("unexpected_event", 32'(k), 0);
        end else begin
          e = q.pop_front();
          check("event_kind",  32'(k), e.kind);
          check("event_cycle", cyc, e.cyc);
          check("event_count", 32'(bus.press_count), e.count);
          check("event_level", 32'(bus.btn_level), e.level);
        end
      end
    end
  end

  initial begin
    // Reset held with the button pressed: nothing may leak through.
    bus.btn_in = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_clear("rst_hold");
    rst_n = 1'b1;
    expect_press(1'b1);
    hold(1'b1, 30);
    wait_drain(20);
    check("held_level", 32'(bus.btn_level), 1);
    check("held_count", 32'(bus.press_count), 1);

    // Release bounce: level must stay high through the short dip.
    bus.btn_in = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rel_bounce_level", 32'(bus.btn_level), 1);
    end
    bus.btn_in = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("rel_bounce_level", 32'(bus.btn_level), 1);
    end
    expect_release();
    hold(1'b0, 12);
    wait_drain(20);
    check("released_level", 32'(bus.btn_level), 0);

    // Press bounce: 3 high samples then 2 low, then a stable press.
    hold(1'b1, 3);
    hold(1'b0, 2);
    check("press_bounce_level", 32'(bus.btn_level), 0);
    expect_press(1'b1);
    hold(1'b1, 25);
    expect_release();
    hold(1'b0, 12);
    wait_drain(20);
    check("bounce_count", 32'(bus.press_count), 2);

    // Count wrap over 256 clean presses.
    rst_n = 1'b0;
    q.delete();
    exp_count = 0;
    bus.btn_in = 1'b0;
    repeat (2) @(negedge clk);
    check_clear("rst_wrap");
    rst_n = 1'b1;
    hold(1'b0, 2);
    for (int i = 0; i < 256; i++) begin
      expect_press(1'b0);
      hold(1'b1, 7);
      if (i == 254) check("wrap_255", 32'(bus.press_count), 255);
      if (i == 255) check("wrap_0", 32'(bus.press_count), 0);
      expect_release();
      hold(1'b0, 8);
    end
    wait_drain(20);

    // Asynchronous reset while in PRESS_WAIT with the debounce count at 2.
    bus.btn_in = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_clear("rst_pw");
    q.delete();
    exp_count = 0;
    @(negedge clk);
    rst_n = 1'b1;
    expect_press(1'b0);
    hold(1'b1, 8);
    check("pw_repress_count", 32'(bus.press_count), 1);
    expect_release();
    hold(1'b0, 10);

    // Build the count up to 5, then reset while PRESSED.
    for (int i = 0; i < 3; i++) begin
      expect_press(1'b0);
      hold(1'b1, 7);
      expect_release();
      hold(1'b0, 8);
    end
    expect_press(1'b0);
    hold(1'b1, 8);
    check("pre_rst_count", 32'(bus.press_count), 5);
    check("pre_rst_level", 32'(bus.btn_level), 1);
    #2 rst_n = 1'b0;
    #1 check_clear("rst_pressed");
    q.delete();
    exp_count = 0;
    @(negedge clk);
    rst_n = 1'b1;
    expect_press(1'b0);
    hold(1'b1, 8);
    check("pressed_repress_count", 32'(bus.press_count), 1);
    expect_release();
    hold(1'b0, 10);
    wait_drain(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Debounces one raw, active-high push-button input and turns it into a clean level plus single-cycle press, release and long-press events. It is the input-side counterpart of the LED blinker: it converts human-driven board I/O into clean clock-domain signals. It sits directly behind a board button pin and feeds control logic or LED displays. It also keeps an 8-bit wrapping count of accepted presses.

## Interface
- DEBOUNCE_CYCLES, 1_000_000 — consecutive synchronised samples at the new level needed to accept a change; legal range ≥ 2.
- HOLD_CYCLES, 100_000_000 — cycles after press_pulse at which long_press fires; legal range ≥ 1.
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset. Deassertion is synchronised upstream.
- btn_in  input  1  raw button, asynchronous, 1 = pressed.
- btn_level  output  1  debounced level, registered.
- press_pulse  output  1  one-cycle pulse on an accepted press.
- release_pulse  output  1  one-cycle pulse on an accepted release.
- long_press  output  1  one-cycle pulse when a press has lasted HOLD_CYCLES; fires at most once per press.
- press_count  output  8  count of accepted presses; wraps from 255 to 0.

## Operation
- Synchroniser: two flops, s1 ← btn_in and s2 ← s1, both reset to 0. Only s2 feeds the rest of the logic.
- Debounce counter: width $clog2(DEBOUNCE_CYCLES+1).
- Hold counter: width $clog2(HOLD_CYCLES+1); saturates at HOLD_CYCLES.
- The FSM has four states: IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT. Reset state is IDLE.
- IDLE:
  - s2=1 → PRESS_WAIT, debounce count ← 1.
  - s2=0 → stay; debounce count held at 0.
- PRESS_WAIT:
  - s2=0 → IDLE, debounce count ← 0. No outputs change.
  - s2=1 and count = DEBOUNCE_CYCLES−1 → PRESSED. On the same edge: btn_level ← 1, press_pulse ← 1, press_count ← press_count+1 (mod 256), hold count ← 0, debounce count ← 0.
  - s2=1 otherwise → count + 1.
- PRESSED:
  - s2=0 → RELEASE_WAIT, debounce count ← 1.
  - Hold count increments every cycle in this state.
- RELEASE_WAIT:
  - s2=1 → PRESSED, debounce count ← 0. btn_level stays 1 and no pulse is generated.
  - s2=0 and count = DEBOUNCE_CYCLES−1 → IDLE. On the same edge: btn_level ← 0, release_pulse ← 1, hold count ← 0.
  - s2=0 otherwise → count + 1.
  - Hold count keeps incrementing in this state, because the button is still considered pressed.
- long_press: pulses for one cycle on the edge where the hold count goes from HOLD_CYCLES−1 to HOLD_CYCLES. Because the counter saturates, the pulse never repeats within one press. It may fire in RELEASE_WAIT.
- Event exclusivity: press_pulse and release_pulse are never high together. long_press is never high together with either of them.

## Timing
- Reset: while rst_n=0, all of the following are 0 immediately, with no clock needed: btn_level, press_pulse, release_pulse, long_press, press_count, both counters, s1 and s2. State is IDLE.
- Press latency: take edge 1 as the first edge that samples btn_in=1, with btn_in stable from then on. btn_level and press_pulse become high after edge DEBOUNCE_CYCLES+2.
- Release latency: symmetrical to press latency, DEBOUNCE_CYCLES+2 edges.
- Glitch filtering: any excursion of s2 shorter than DEBOUNCE_CYCLES samples changes no output. The counter restarts from scratch on the next excursion.
- long_press timing: high exactly HOLD_CYCLES edges after the edge on which press_pulse is high.
- Output pulses are exactly one cycle wide. All outputs are direct flop outputs, with no combinational path from btn_in.
- Reset mid-operation (any state) → immediate return to the full reset state. After rst_n deasserts, a held button is re-accepted with the normal press latency.

## Test plan
Directed scenarios use DEBOUNCE_CYCLES=4 and HOLD_CYCLES=10.
- Reset with btn_in=1 throughout, then release rst_n → all outputs 0 during reset; after rst_n release, btn_level=1 and press_pulse=1 after edge 6, and press_count=1.
- Press bounce: btn_in=1 for 3 cycles, 0 for 2 cycles, then stable 1 → no pulses during the bounce; press_pulse only 6 edges after the stable 1 begins.
- Long press: hold btn_in=1 for 30 cycles → a single long_press exactly 10 edges after press_pulse, not repeated.
- Release bounce: from PRESSED, btn_in=0 for 2 cycles, back to 1, then stable 0 → btn_level stays 1 through the bounce; release_pulse and btn_level=0 come 6 edges after the stable 0 begins.
- Wrap: 256 clean presses → press_count reads 255 after the 255th press and 0 after the 256th.
- Reset in PRESS_WAIT (debounce count 2), and separately in PRESSED with press_count=5 → all outputs and the count clear immediately; a held button re-presses after 6 edges with press_count=1.
